// File: rtl/urv_defs.sv
// ---------------------------------------------------------------------------
// urv_defs -- shared definitions for the instruction-fetch bridge.
//
// Contents:
//   imem_state_t  bridge FSM state encoding (IDLE / BUS)
//   SEL_ALL       Wishbone byte-select for full-word reads
//   WE_READ       Wishbone write-enable level for reads
//   NUM_ENTRIES   number of word buffers (1, or 2 with URV_IMEM_PREFETCH_EN)
//   tag_width()   word-tag width derived from the compared address width
// ---------------------------------------------------------------------------
package urv_defs;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } imem_state_t;

  localparam logic [3:0] SEL_ALL = 4'hf;
  localparam logic       WE_READ = 1'b0;

`ifdef URV_IMEM_PREFETCH_EN
  localparam int NUM_ENTRIES = 2;
`else
  localparam int NUM_ENTRIES = 1;
`endif

  // Tags identify 32-bit words, so the two byte-offset bits are dropped.
  function automatic int tag_width(input int addr_width);
    return addr_width - 2;
  endfunction

endpackage

// File: rtl/rv_imem_entry.sv
// ---------------------------------------------------------------------------
// rv_imem_entry -- one buffered instruction word: tag, data and valid bit,
// with a lookup comparator and a second "probe" comparator.
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset (clears valid)
//   lookup_tag     tag of the current fetch request
//   probe_tag      tag checked for presence without affecting the lookup
//   fill_en        store fill_tag/fill_data and mark the entry valid
//   fill_tag       word tag to store
//   fill_data      instruction word to store
//   inv_en         invalidate the entry; wins over a same-edge fill
//   hit            entry valid and tag == lookup_tag
//   probe_hit      entry valid and tag == probe_tag
//   data           stored instruction word
// ---------------------------------------------------------------------------
module rv_imem_entry #(
  parameter int g_tag_width = 30
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [g_tag_width-1:0] lookup_tag,
  input  logic [g_tag_width-1:0] probe_tag,
  input  logic                   fill_en,
  input  logic [g_tag_width-1:0] fill_tag,
  input  logic [31:0]            fill_data,
  input  logic                   inv_en,
  output logic                   hit,
  output logic                   probe_hit,
  output logic [31:0]            data
);

  logic                   valid_reg;
  logic [g_tag_width-1:0] tag_reg;
  logic [31:0]            data_reg;

  // A flush that lands on the same edge as a fill must leave the entry
  // empty, so invalidation takes priority over the fill.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_reg <= 1'b0;
      tag_reg   <= '0;
      data_reg  <= '0;
    end else if (inv_en) begin
      valid_reg <= 1'b0;
    end else if (fill_en) begin
      valid_reg <= 1'b1;
      tag_reg   <= fill_tag;
      data_reg  <= fill_data;
    end
  end

  assign hit       = valid_reg && (tag_reg == lookup_tag);
  assign probe_hit = valid_reg && (tag_reg == probe_tag);
  assign data      = data_reg;

endmodule

// File: rtl/rv_imem_bridge.sv
// ---------------------------------------------------------------------------
// rv_imem_bridge -- responder for the core's instruction-fetch port.
//
// The address sampled at a clock edge is the request; im_valid_o/im_data_o
// answer it in the following cycle. Hits in the word buffer are served in
// one cycle; misses are fetched with a Wishbone classic read.
//
// Parameters:
//   g_addr_width   low address bits compared for hits and driven on
//                  wb_adr_o (upper bits of wb_adr_o are 0)
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   im_addr_i      fetch address (bits [1:0] ignored)
//   im_data_o      instruction word for the previously sampled address
//   im_valid_o     im_data_o valid this cycle
//   im_flush_i     single-cycle pulse, invalidates all buffered words
//   wb_cyc_o/stb_o Wishbone cycle / strobe
//   wb_adr_o       word-aligned read address
//   wb_sel_o       always 4'hf
//   wb_we_o        always 0
//   wb_dat_i       read data
//   wb_ack_i       acknowledge
//
// Build option:
//   URV_IMEM_PREFETCH_EN  adds a second entry (P) filled by a speculative
//                         read of A+4 after each delivered word at A.
// ---------------------------------------------------------------------------
module rv_imem_bridge
  import urv_defs::*;
#(
  parameter int g_addr_width = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] im_addr_i,
  output logic [31:0] im_data_o,
  output logic        im_valid_o,
  input  logic        im_flush_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  localparam int TAG_W = tag_width(g_addr_width);

  imem_state_t state_reg;

  logic [TAG_W-1:0] req_tag;
  logic [TAG_W-1:0] req_tag_inc;
  logic [TAG_W-1:0] bus_tag;
  logic             bus_ack;
  logic             bus_match;
  logic             any_hit;
  logic [31:0]      hit_data;

  logic             d_fill;
  logic             d_hit;
  logic             d_probe_unused;
  logic [31:0]      d_data;

  logic             addr_bits_unused;

  assign req_tag     = im_addr_i[g_addr_width-1:2];
  assign req_tag_inc = req_tag + TAG_W'(1);  // wraps modulo 2^g_addr_width
  assign bus_tag     = wb_adr_o[g_addr_width-1:2];
  assign bus_ack     = (state_reg == ST_BUS) && wb_ack_i;

  // Byte-offset bits (and any bits above g_addr_width) take no part.
  assign addr_bits_unused = ^im_addr_i;

  assign wb_sel_o = SEL_ALL;
  assign wb_we_o  = WE_READ;

`ifdef URV_IMEM_PREFETCH_EN
  logic        pf_reg;          // the outstanding read is a prefetch
  logic        pf_nostore_reg;  // a flush hit while that prefetch was in flight
  logic        p_fill;
  logic        p_hit;
  logic        p_probe_hit;
  logic [31:0] p_data;
  logic        need_pf;

  assign d_fill   = bus_ack && !pf_reg;
  assign p_fill   = bus_ack && pf_reg && !pf_nostore_reg;
  assign any_hit  = d_hit || p_hit;
  assign hit_data = d_hit ? d_data : p_data;

  // A prefetch overtaken by a flush may hold stale code: it is neither
  // stored nor handed to the core; the core's request is re-evaluated.
  assign bus_match = (req_tag == bus_tag) && !(pf_reg && pf_nostore_reg);

  // P keeps A+4 across this edge only if it holds it now and is neither
  // flushed nor overwritten by a prefetch fill at the same edge.
  assign need_pf = !(p_probe_hit && !im_flush_i && !p_fill);

  rv_imem_entry #(
    .g_tag_width (TAG_W)
  ) u_entry_p (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .lookup_tag (req_tag),
    .probe_tag  (req_tag_inc),
    .fill_en    (p_fill),
    .fill_tag   (bus_tag),
    .fill_data  (wb_dat_i),
    .inv_en     (im_flush_i),
    .hit        (p_hit),
    .probe_hit  (p_probe_hit),
    .data       (p_data)
  );
`else
  assign d_fill    = bus_ack;
  assign any_hit   = d_hit;
  assign hit_data  = d_data;
  assign bus_match = (req_tag == bus_tag);
`endif

  rv_imem_entry #(
    .g_tag_width (TAG_W)
  ) u_entry_d (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .lookup_tag (req_tag),
    .probe_tag  (req_tag_inc),
    .fill_en    (d_fill),
    .fill_tag   (bus_tag),
    .fill_data  (wb_dat_i),
    .inv_en     (im_flush_i),
    .hit        (d_hit),
    .probe_hit  (d_probe_unused),
    .data       (d_data)
  );

  // Control FSM. All outputs are registered here; where two assignments
  // to the same output can occur on one edge, the later one (a chained
  // prefetch issue) is intended to win.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= ST_IDLE;
      im_valid_o     <= 1'b0;
      im_data_o      <= '0;
      wb_cyc_o       <= 1'b0;
      wb_stb_o       <= 1'b0;
      wb_adr_o       <= '0;
`ifdef URV_IMEM_PREFETCH_EN
      pf_reg         <= 1'b0;
      pf_nostore_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (any_hit) begin
            im_valid_o <= 1'b1;
            im_data_o  <= hit_data;
`ifdef URV_IMEM_PREFETCH_EN
            if (need_pf) begin
              wb_adr_o       <= 32'({req_tag_inc, 2'b00});
              wb_cyc_o       <= 1'b1;
              wb_stb_o       <= 1'b1;
              pf_reg         <= 1'b1;
              pf_nostore_reg <= 1'b0;
              state_reg      <= ST_BUS;
            end
`endif
          end else begin
            im_valid_o <= 1'b0;
            wb_adr_o   <= 32'({req_tag, 2'b00});
            wb_cyc_o   <= 1'b1;
            wb_stb_o   <= 1'b1;
            state_reg  <= ST_BUS;
`ifdef URV_IMEM_PREFETCH_EN
            pf_reg         <= 1'b0;
            pf_nostore_reg <= 1'b0;
`endif
          end
        end

        ST_BUS: begin
          im_valid_o <= 1'b0;
          // Classic cycles cannot be aborted: wait for the ack even if the
          // requester has moved on to another address.
          if (wb_ack_i) begin
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            state_reg <= ST_IDLE;
`ifdef URV_IMEM_PREFETCH_EN
            pf_reg    <= 1'b0;
`endif
            if (bus_match) begin
              im_valid_o <= 1'b1;
              im_data_o  <= wb_dat_i;
`ifdef URV_IMEM_PREFETCH_EN
              if (need_pf) begin
                wb_adr_o       <= 32'({req_tag_inc, 2'b00});
                wb_cyc_o       <= 1'b1;
                wb_stb_o       <= 1'b1;
                pf_reg         <= 1'b1;
                pf_nostore_reg <= 1'b0;
                state_reg      <= ST_BUS;
              end
`endif
            end
          end
`ifdef URV_IMEM_PREFETCH_EN
          else if (im_flush_i && pf_reg) begin
            pf_nostore_reg <= 1'b1;
          end
`endif
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
